// File: rtl/xlmc_pkg.sv
// Shared types and default timing constants for the Xccela/OPI memory controller.
// The CE#/clock-enable sequencer and the controller top level both import this package.
package xlmc_pkg;

    typedef enum logic [2:0] {
        XLMC_IDLE,
        XLMC_SETUP,
        XLMC_BURST,
        XLMC_HOLD,
        XLMC_RECOV
    } xlmc_cen_st_t;

    localparam int unsigned XLMC_CSS_CYC_DEF  = 2;
    localparam int unsigned XLMC_CSH_CYC_DEF  = 1;
    localparam int unsigned XLMC_CPH_CYC_DEF  = 4;
    localparam int unsigned XLMC_TCEM_CYC_DEF = 400;

    // The IDLE cycle in which the next request is accepted is the last CE#-high
    // cycle, so RECOV itself lasts one cycle less than the CE# high minimum.
    function automatic int unsigned xlmc_recov_cyc(input int unsigned cph);
        return (cph > 1) ? cph - 1 : 1;
    endfunction

endpackage

// File: rtl/xlmc_cen_seq.sv
// Transaction clock-enable sequencer: frames CE# setup, an N-clock burst, CE# hold and CE# recovery.
// Optional tCEM limit checker is built when XLMC_TCEM_CHK_EN is defined.
module xlmc_cen_seq
    import xlmc_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned CSS_CYC  = XLMC_CSS_CYC_DEF,
    parameter int unsigned CSH_CYC  = XLMC_CSH_CYC_DEF,
    parameter int unsigned CPH_CYC  = XLMC_CPH_CYC_DEF,
    parameter int unsigned TCEM_CYC = XLMC_TCEM_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_ncyc,
    input  logic             abort,
    output logic             cen,
    output logic             xl_ce_n,
    output logic [CNT_W-1:0] ck_idx,
    output logic             busy,
    output logic             done,
    output logic             tcem_err
);

    if (CNT_W < 4 || CSS_CYC < 1 || CSS_CYC > 15 || CSH_CYC < 1 || CSH_CYC > 15 ||
        CPH_CYC < 1 || CPH_CYC > 15 || TCEM_CYC < 1) begin : g_bad_param
        $error("xlmc_cen_seq: timing parameter out of range");
    end

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CSS_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CSH_CYC - 1);
    localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(xlmc_recov_cyc(CPH_CYC) - 1);

    xlmc_cen_st_t     st_q, st_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] ncyc_q, ncyc_d;
    logic [CNT_W-1:0] ck_idx_q, ck_idx_d;
    logic             cen_q, cen_d;
    logic             ce_n_q, ce_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rdy_q, rdy_d;
    logic             tcem_hit;
    logic             cut;

`ifdef XLMC_TCEM_CHK_EN
    localparam int unsigned TCEM_W = $clog2(TCEM_CYC + 1);

    logic [TCEM_W-1:0] ce_cnt_q, ce_cnt_d;
    logic              tcem_err_q, tcem_err_d;

    assign tcem_hit = (ce_cnt_q >= TCEM_W'(TCEM_CYC));
`else
    assign tcem_hit = 1'b0;
`endif

    assign cut = abort || tcem_hit;

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        st_d     = st_q;
        tmr_d    = tmr_q;
        ncyc_d   = ncyc_q;
        ck_idx_d = ck_idx_q;
        done_d   = 1'b0;

        unique case (st_q)
            XLMC_IDLE: begin
                if (req_valid && rdy_q) begin
                    st_d     = XLMC_SETUP;
                    tmr_d    = SETUP_LD;
                    ncyc_d   = req_ncyc;
                    ck_idx_d = '0;
                end
            end
            XLMC_SETUP: begin
                if (cut) begin
                    st_d  = XLMC_HOLD;
                    tmr_d = HOLD_LD;
                end else if (tmr_q == '0) begin
                    if (ncyc_q != '0) begin
                        st_d  = XLMC_BURST;
                        tmr_d = ncyc_q - CNT_W'(1);
                    end else begin
                        st_d  = XLMC_HOLD;
                        tmr_d = HOLD_LD;
                    end
                end else begin
                    tmr_d = tmr_q - CNT_W'(1);
                end
            end
            XLMC_BURST: begin
                // Abort on the last cycle lands here too, so it matches normal completion.
                if (cut || tmr_q == '0) begin
                    st_d  = XLMC_HOLD;
                    tmr_d = HOLD_LD;
                end else begin
                    tmr_d    = tmr_q - CNT_W'(1);
                    ck_idx_d = ck_idx_q + CNT_W'(1);
                end
            end
            XLMC_HOLD: begin
                if (tmr_q == '0) begin
                    st_d   = XLMC_RECOV;
                    tmr_d  = RECOV_LD;
                    done_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - CNT_W'(1);
                end
            end
            XLMC_RECOV: begin
                if (tmr_q == '0) begin
                    st_d = XLMC_IDLE;
                end else begin
                    tmr_d = tmr_q - CNT_W'(1);
                end
            end
            default: begin
                st_d = XLMC_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so cen moves only on a clk edge.
        cen_d  = (st_d == XLMC_BURST);
        ce_n_d = (st_d == XLMC_IDLE) || (st_d == XLMC_RECOV);
        busy_d = (st_d != XLMC_IDLE);
        rdy_d  = (st_d == XLMC_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= XLMC_IDLE;
            tmr_q    <= '0;
            ncyc_q   <= '0;
            ck_idx_q <= '0;
            cen_q    <= 1'b0;
            ce_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            tmr_q    <= tmr_d;
            ncyc_q   <= ncyc_d;
            ck_idx_q <= ck_idx_d;
            cen_q    <= cen_d;
            ce_n_q   <= ce_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdy_q    <= rdy_d;
        end
    end

`ifdef XLMC_TCEM_CHK_EN
    // Counts CE#-low cycles including the current one; saturates at the limit.
    always_comb begin
        ce_cnt_d = '0;
        if (!ce_n_d) begin
            if (st_q == XLMC_IDLE) begin
                ce_cnt_d = TCEM_W'(1);
            end else if (tcem_hit) begin
                ce_cnt_d = ce_cnt_q;
            end else begin
                ce_cnt_d = ce_cnt_q + TCEM_W'(1);
            end
        end
        tcem_err_d = tcem_err_q ||
                     (tcem_hit && (st_q == XLMC_SETUP || st_q == XLMC_BURST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_cnt_q   <= '0;
            tcem_err_q <= 1'b0;
        end else begin
            ce_cnt_q   <= ce_cnt_d;
            tcem_err_q <= tcem_err_d;
        end
    end

    assign tcem_err = tcem_err_q;
`else
    assign tcem_err = 1'b0;
`endif

    assign req_ready = rdy_q;
    assign cen       = cen_q;
    assign xl_ce_n   = ce_n_q;
    assign ck_idx    = ck_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
